ps2_key_event_ctrl: RTL
=======================

// Module: ps2_key_event_ctrl
// PURPOSE
//  Sequencer between the ps2_keyboard byte receiver and display/CPU consumers. Pops raw scan bytes over a
//  valid/ready handshake and decodes make, break (F0) and extended (E0) prefix sequences into single key
//  events. Tracks shift and held-key state, counts new presses and translates each event to ASCII.
// PARAMETERS
//  PREFIX_TIMEOUT  2_000_000  cycles allowed between a prefix byte and its completing byte
//  CNT_W           8          width of press counter
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      ps2_keyboard has a scan byte ready
//  in_data     in   8      scan byte
//  in_ready    out  1      byte popped this cycle when in_valid&&in_ready
//  ev_valid    out  1      key event available
//  ev_ready    in   1      consumer accepts event
//  ev_code     out  8      scan code without prefixes
//  ev_ext      out  1      event was E0-prefixed
//  ev_make     out  1      1=press/repeat, 0=release
//  ev_repeat   out  1      make of code already held (typematic)
//  ev_ascii    out  8      ASCII of ev_code, 8'h00 if unmapped or ext
//  shift       out  1      either shift currently held
//  press_cnt   out  CNT_W  count of new presses, wraps
//  held_valid  out  1      a non-shift key is held
//  held_code   out  8      most recently pressed non-shift code
//  proto_err   out  1      one-cycle pulse on sequence error or timeout
// BEHAVIOUR
//  Reset (sync): all outputs 0, FSM=IDLE, timeout counter 0. Reset mid-sequence or mid-event discards it.
//  FSM: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), EMIT.
//  in_ready=1 in IDLE/EXT/BRK/EXT_BRK, 0 in EMIT (and during rst). Bytes are acted on only when accepted.
//  IDLE: E0->EXT; F0->BRK; 00/AA/FA/FE/FF ignored (stay IDLE); other -> make event, go EMIT.
//  EXT: F0->EXT_BRK; E0->proto_err, stay EXT; other -> ext make event. BRK: E0 or F0 -> proto_err;
//   E0 goes to EXT, F0 stays BRK; other -> break event. EXT_BRK: E0/F0 -> proto_err, go IDLE; other -> ext break.
//  Event capture: ev_* registered on accept cycle t; ev_valid=1 at t+1 (1-cycle latency). In EMIT ev_* hold
//   stable until ev_valid&&ev_ready, then ev_valid=0 next cycle and FSM -> IDLE. No combinational in->out path.
//  Shift: non-ext make 12/59 sets that side's flag, break clears it; shift=L|R. Shift events are still emitted.
//   Shift flags are updated in the capture cycle, so a shift event's own ev_ascii reflects the new shift state.
//  ASCII: table covers digits 0-9 and letters a-z. Letters are uppercase (minus 8'h20) when shift is set at
//   capture; digits are unaffected; unmapped or ext codes give 8'h00.
//  Held: non-shift make of code==held_code with held_valid -> ev_repeat=1, press_cnt unchanged.
//   Any other non-shift make -> press_cnt+1 (FF->00 wrap), held_code=code, held_valid=1.
//   Break matching held_code and ext -> held_valid=0. Break of a non-held key -> event emitted, held unchanged.
//   held_code compares code+ext: held state stores the ext bit internally.
//  Timeout: counter clears on every accept and counts only in EXT/BRK/EXT_BRK. On reaching
//   PREFIX_TIMEOUT-1 -> proto_err pulse, FSM->IDLE. An accept in that same cycle wins (no error).
//  proto_err never coincides with reset; it is 0 in the rst cycle.
// STRUCTURE
//  ps2_defs.vh: localparams for PS2_EXT=E0, PS2_BRK=F0, LSHIFT=12, RSHIFT=59, ignored response codes,
//   FSM state encodings; shared with ps2_keyboard and top.
//  Sub-module ps2_scan_ascii: combinational case ROM, code[7:0] -> lowercase ascii[7:0]. Replaces the
//   reset-loaded table in top. The shift adjust stays in this block.
// TESTING
//  1) Bytes 1C, F0 1C with ev_ready=1 -> make{1C,'a'=61,cnt=1}, break{1C,make=0}; held_valid 1 then 0.
//  2) 12, 1C, F0 12, F0 1C -> ascii 00,'A'=41,00,'a'=61; shift 1 then 0; press_cnt=1 (shift excluded).
//  3) E0 75, E0 F0 75 -> ev_ext=1 both, ascii=00; E0 F0 seq pops 3 bytes and emits exactly one event.
//  4) 1C x3 typematic -> 1st ev_repeat=0, next two ev_repeat=1; press_cnt=1. 256 distinct presses -> cnt wraps to 00.
//  5) ev_ready=0 for 10 cycles after make -> in_ready=0, ev_* stable, later byte not lost.
//  6) F0 then idle PREFIX_TIMEOUT(=16 in test) cycles -> proto_err 1 cycle, IDLE. Also F0 F0 -> proto_err.
//     rst mid-EXT -> all outputs 0.

Source files
------------

// File: rtl/ps2_key_event_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : ps2_key_event_ctrl_pkg
// Brief    : Shared PS/2 scan-code constants, FSM encoding and byte classifiers.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ps2_key_event_ctrl_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] LSHIFT  = 8'h12;
  localparam logic [7:0] RSHIFT  = 8'h59;

  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_EMIT    = 3'd4
  } state_e;

  // Keyboard self-test / ack / resend / error responses carry no key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

  function automatic logic is_lower_letter(input logic [7:0] a);
    return (a >= 8'h61) && (a <= 8'h7A);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_scan_ascii.sv
//------------------------------------------------------------------------------
// Module   : ps2_scan_ascii
// Brief    : Set-2 scan code to lowercase ASCII ROM (digits and letters only).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_scan_ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      default: ascii = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_event_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ps2_key_event_ctrl
// Brief    : Folds E0/F0 prefixed PS/2 scan bytes into single key events with
//            shift, held-key, press-count and ASCII tracking.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_key_event_ctrl
  import ps2_key_event_ctrl_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 2_000_000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_make,
  output logic             ev_repeat,
  output logic [7:0]       ev_ascii,
  output logic             shift,
  output logic [CNT_W-1:0] press_cnt,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             proto_err
);

  localparam int              TO_W    = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  state_e             state_q,      state_d;
  logic [TO_W-1:0]    to_cnt_q,     to_cnt_d;
  logic               ev_valid_q,   ev_valid_d;
  logic [7:0]         ev_code_q,    ev_code_d;
  logic               ev_ext_q,     ev_ext_d;
  logic               ev_make_q,    ev_make_d;
  logic               ev_repeat_q,  ev_repeat_d;
  logic [7:0]         ev_ascii_q,   ev_ascii_d;
  logic               lshift_q,     lshift_d;
  logic               rshift_q,     rshift_d;
  logic [CNT_W-1:0]   press_cnt_q,  press_cnt_d;
  logic               held_valid_q, held_valid_d;
  logic [7:0]         held_code_q,  held_code_d;
  logic               held_ext_q,   held_ext_d;
  logic               proto_err_q,  proto_err_d;

  logic       w_accept;
  logic       w_timeout;
  logic       w_in_prefix;
  logic       w_capture;
  logic       w_cap_ext;
  logic       w_cap_make;
  logic       w_is_shift;
  logic       w_held_match;
  logic [7:0] w_rom_ascii;

  ps2_scan_ascii u_scan_ascii (
    .code  (in_data),
    .ascii (w_rom_ascii)
  );

  assign in_ready    = !rst && (state_q != ST_EMIT);
  assign w_accept    = in_valid && in_ready;
  assign w_in_prefix = (state_q == ST_EXT) || (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  assign w_timeout   = w_in_prefix && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    ev_valid_d   = ev_valid_q;
    proto_err_d  = 1'b0;
    w_capture    = 1'b0;
    w_cap_ext    = 1'b0;
    w_cap_make   = 1'b0;

    // Accepting a byte restarts the prefix window; expiry is only honoured
    // when nothing was accepted in the same cycle.
    if (w_accept || !w_in_prefix || w_timeout) to_cnt_d = '0;
    else                                       to_cnt_d = to_cnt_q + TO_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_data == PS2_EXT)       state_d = ST_EXT;
          else if (in_data == PS2_BRK)  state_d = ST_BRK;
          else if (!is_ignored(in_data)) begin
            w_capture  = 1'b1;
            w_cap_make = 1'b1;
          end
        end
      end
      ST_EXT: begin
        if (w_accept) begin
          if (in_data == PS2_BRK)       state_d = ST_EXT_BRK;
          else if (in_data == PS2_EXT)  proto_err_d = 1'b1;
          else begin
            w_capture  = 1'b1;
            w_cap_ext  = 1'b1;
            w_cap_make = 1'b1;
          end
        end else if (w_timeout) begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_BRK: begin
        if (w_accept) begin
          if (in_data == PS2_EXT) begin
            proto_err_d = 1'b1;
            state_d     = ST_EXT;
          end else if (in_data == PS2_BRK) begin
            proto_err_d = 1'b1;
          end else begin
            w_capture = 1'b1;
          end
        end else if (w_timeout) begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_EXT_BRK: begin
        if (w_accept) begin
          if ((in_data == PS2_EXT) || (in_data == PS2_BRK)) begin
            proto_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            w_capture = 1'b1;
            w_cap_ext = 1'b1;
          end
        end else if (w_timeout) begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (ev_valid_q && ev_ready) begin
          ev_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_capture) begin
      state_d    = ST_EMIT;
      ev_valid_d = 1'b1;
    end
  end

  // Event payload, shift flags and held-key bookkeeping, all on the capture cycle.
  always_comb begin
    ev_code_d    = ev_code_q;
    ev_ext_d     = ev_ext_q;
    ev_make_d    = ev_make_q;
    ev_repeat_d  = ev_repeat_q;
    ev_ascii_d   = ev_ascii_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    press_cnt_d  = press_cnt_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;

    w_is_shift   = !w_cap_ext && ((in_data == LSHIFT) || (in_data == RSHIFT));
    w_held_match = held_valid_q && (held_code_q == in_data) && (held_ext_q == w_cap_ext);

    if (w_capture) begin
      ev_code_d   = in_data;
      ev_ext_d    = w_cap_ext;
      ev_make_d   = w_cap_make;
      ev_repeat_d = 1'b0;

      if (w_is_shift) begin
        if (in_data == LSHIFT) lshift_d = w_cap_make;
        else                   rshift_d = w_cap_make;
      end else if (w_cap_make) begin
        if (w_held_match) begin
          ev_repeat_d = 1'b1;
        end else begin
          press_cnt_d  = press_cnt_q + CNT_W'(1);
          held_valid_d = 1'b1;
          held_code_d  = in_data;
          held_ext_d   = w_cap_ext;
        end
      end else if (w_held_match) begin
        held_valid_d = 1'b0;
      end

      // Uses the post-update shift so a shift event reports its own effect.
      if (w_cap_ext)
        ev_ascii_d = 8'h00;
      else if ((lshift_d || rshift_d) && is_lower_letter(w_rom_ascii))
        ev_ascii_d = w_rom_ascii - ASCII_CASE_OFS;
      else
        ev_ascii_d = w_rom_ascii;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      to_cnt_q     <= '0;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= 8'h00;
      ev_ext_q     <= 1'b0;
      ev_make_q    <= 1'b0;
      ev_repeat_q  <= 1'b0;
      ev_ascii_q   <= 8'h00;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      press_cnt_q  <= '0;
      held_valid_q <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_ext_q     <= ev_ext_d;
      ev_make_q    <= ev_make_d;
      ev_repeat_q  <= ev_repeat_d;
      ev_ascii_q   <= ev_ascii_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      press_cnt_q  <= press_cnt_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_code    = ev_code_q;
  assign ev_ext     = ev_ext_q;
  assign ev_make    = ev_make_q;
  assign ev_repeat  = ev_repeat_q;
  assign ev_ascii   = ev_ascii_q;
  assign shift      = lshift_q || rshift_q;
  assign press_cnt  = press_cnt_q;
  assign held_valid = held_valid_q;
  assign held_code  = held_code_q;
  assign proto_err  = proto_err_q && !rst;

endmodule

`default_nettype wire
